noc_out_arbiter: RTL
====================

Name: noc_out_arbiter

Overview:
- Clocked 2-to-1 merge stage that sits directly downstream of the router input controllers.
- Consumes packets from two input controllers' output branches (in0, in1), each routed toward the same router output port, and serialises them onto a single output link.
- Per-input FIFO buffering decouples the inputs; round-robin arbitration gives fairness; a registered output stage holds data stable under backpressure.

Parameters:
- WIDTH_PACKET, 14, packet width in bits (dest field at bits [10:8]).
- FIFO_DEPTH, 2, entries per input FIFO; power of two, >= 2.
- CNT_W, 16, width of optional grant counters.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in0_data  in  WIDTH_PACKET  packet from input branch 0.
- in0_valid  in  1  in0_data valid.
- in0_ready  out  1  FIFO0 can accept a packet.
- in1_data  in  WIDTH_PACKET  packet from input branch 1.
- in1_valid  in  1  in1_data valid.
- in1_ready  out  1  FIFO1 can accept a packet.
- out_data  out  WIDTH_PACKET  merged output packet (registered).
- out_valid  out  1  out_data valid (registered).
- out_ready  in  1  downstream accepts out_data.
- out_src  out  1  source of current out_data (0 = in0, 1 = in1), registered.

Behaviour:
- Reset (rst_n low, asynchronous): FIFOs empty; out_valid=0, out_data=0, out_src=0, last_grant=1 (so in0 wins first tie); inX_ready=0 while rst_n is low.
- Input handshake: transfer when inX_valid && inX_ready at a rising edge.
  - inX_ready = !fifoX_full (combinational from count).
  - A sender must hold data and valid until the transfer completes.
- FIFO rules:
  - Pointer wrap is modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
  - Push and pop in the same cycle: count unchanged, both legal.
  - No push when full (ready is low). Pop only when non-empty.
- Output register "free" condition: out_valid==0, or (out_valid && out_ready).
- When the output register is free, arbitrate at each edge:
  - Only FIFO0 non-empty: pop FIFO0 → out_data, out_src=0, out_valid=1.
  - Only FIFO1 non-empty: likewise, out_src=1.
  - Both non-empty: grant !last_grant, then last_grant = granted index.
  - Both empty: out_valid=0 if the register was just drained; otherwise it stays 0.
- Backpressure: while out_valid && !out_ready, out_data, out_src and out_valid are held stable and no FIFO pops.
- Latency: packet accepted at edge k (FIFO empty, output free) is presented with out_valid=1 after edge k+1. Throughput is 1 packet/cycle sustained.
- Ordering: per-input order preserved. Under continuous contention, grants alternate strictly 0,1,0,1…
- last_grant updates only on a contested grant; uncontested grants leave it unchanged.
- Mid-operation reset: all buffered packets are discarded and outputs return to reset values immediately.
- Packet contents are never modified. The dest field is passed through and is not inspected.

Optional Feature:
- Macro NOC_ARB_STATS_EN.
- Defined: adds outputs stat_grant0 and stat_grant1 (CNT_W bits each).
  - Each increments on every pop from its FIFO and saturates at all-ones.
  - Both reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package noc_pkg: WIDTH_PACKET, DEST_LSB=8, DEST_MSB=10, packet_t typedef, src_t enum {SRC0, SRC1}.
- Sub-module noc_fifo (parameterised sync FIFO: push/pop/full/empty/count), instantiated twice.
- Arbiter and output register stay in the top level.

Test Plan:
- Reset: hold rst_n=0, drive in0_valid=1 → in0_ready=0, out_valid=0. Release reset → in0_ready=1 next cycle.
- Single packet: in0 sends 14'h2A5 at edge k, out_ready=1 → out_valid=1, out_data=14'h2A5, out_src=0 after edge k+1, for one cycle.
- Contention: both inputs stream 4 packets each (0x100–0x103 on in0, 0x200–0x203 on in1) with out_ready=1 → output order 0x100,0x200,0x101,0x201…; 8 packets in 8 consecutive cycles.
- Backpressure: out_ready=0 for 5 cycles while in1 sends 3 packets →
  - out_data holds the first packet;
  - in1_ready drops after FIFO full (2 buffered + 1 in register);
  - on release, all 3 emerge in order with no loss.
- Mid-stream reset: assert rst_n low with both FIFOs full → out_valid=0 immediately, and no stale packet appears after release.
- NOC_ARB_STATS_EN defined, CNT_W=4: push 17 packets on in0 → stat_grant0=15 (saturated), stat_grant1=0.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared packet layout and source encoding for the router output stage
package noc_pkg;
  localparam int WIDTH_PACKET = 14;
  localparam int DEST_LSB = 8;
  localparam int DEST_MSB = 10;
  typedef logic [WIDTH_PACKET-1:0] packet_t;
  typedef enum logic {SRC0, SRC1} src_t;
endpackage

// File: rtl/noc_fifo.sv
// noc_fifo: synchronous FIFO with count-derived full/empty and a combinational head
module noc_fifo #(
  parameter int W = 14,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/noc_out_arbiter.sv
// noc_out_arbiter: 2-to-1 round-robin merge with per-input FIFOs and a registered output; NOC_ARB_STATS_EN adds saturating grant counters
module noc_out_arbiter #(
  parameter int WIDTH_PACKET = noc_pkg::WIDTH_PACKET,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH_PACKET-1:0] in0_data,
  input  logic                    in0_valid,
  output logic                    in0_ready,
  input  logic [WIDTH_PACKET-1:0] in1_data,
  input  logic                    in1_valid,
  output logic                    in1_ready,
  output logic [WIDTH_PACKET-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef NOC_ARB_STATS_EN
  output logic [CNT_W-1:0]        stat_grant0,
  output logic [CNT_W-1:0]        stat_grant1,
`endif
  output logic                    out_src
);
  import noc_pkg::*;
  logic [WIDTH_PACKET-1:0] d0, d1;
  logic full0, full1, empty0, empty1, push0, push1, pop0, pop1;
  logic free, contested, gnt1, last_grant;
  src_t src_q;
  assign in0_ready = rst_n && !full0;
  assign in1_ready = rst_n && !full1;
  assign push0 = in0_valid && in0_ready;
  assign push1 = in1_valid && in1_ready;
  assign free = !out_valid || out_ready;
  assign contested = !empty0 && !empty1;
  // on a tie the input that did not win the last contested grant goes first
  assign gnt1 = !empty1 && (empty0 || !last_grant);
  assign pop1 = free && gnt1;
  assign pop0 = free && !empty0 && !gnt1;
  assign out_src = src_q;
  noc_fifo #(.W(WIDTH_PACKET), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(clk), .rst_n(rst_n), .push(push0), .pop(pop0), .din(in0_data),
    .dout(d0), .full(full0), .empty(empty0)
  );
  noc_fifo #(.W(WIDTH_PACKET), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .push(push1), .pop(pop1), .din(in1_data),
    .dout(d1), .full(full1), .empty(empty1)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      src_q <= SRC0;
      last_grant <= 1'b1;
    end else if (free) begin
      out_valid <= pop0 || pop1;
      if (pop0 || pop1) begin
        out_data <= gnt1 ? d1 : d0;
        src_q <= gnt1 ? SRC1 : SRC0;
      end
      if (contested) last_grant <= gnt1;
    end
  end
`ifdef NOC_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
    end else begin
      stat_grant0 <= stat_grant0 + CNT_W'(pop0 && !(&stat_grant0));
      stat_grant1 <= stat_grant1 + CNT_W'(pop1 && !(&stat_grant1));
    end
  end
`endif
endmodule
